// File: rtl/regbank_arbiter.sv
// regbank_arbiter: sole owner of the 37-entry register bank ports. Arbitrates
// between fetch (PC read+increment), execute (3 reads or 1 write) and writeback
// (1 write), maps architectural indices to physical bank indices using the
// CPSR mode sampled at grant, and runs one IDLE -> ACCESS -> RESP op at a time.
module regbank_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] CPSR_WMASK   = 32'hF00000FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  cpsr_mode,
    input  logic        f_req,
    output logic        f_ack,
    output logic [31:0] f_pc,
    input  logic        e_req,
    input  logic        e_we,
    input  logic [14:0] e_raddr,
    input  logic [4:0]  e_waddr,
    input  logic [31:0] e_wdata,
    output logic        e_ack,
    output logic        e_err,
    output logic [95:0] e_rdata,
    input  logic        w_req,
    input  logic [4:0]  w_addr,
    input  logic [31:0] w_data,
    output logic        w_ack,
    output logic        w_err,
    output logic        bank_active,
    output logic        bank_w,
    output logic        bank_pc_inc,
    output logic        bank_cpsr_w,
    output logic [17:0] bank_addr,
    output logic [31:0] bank_write,
    output logic [31:0] bank_cpsr_mask,
    input  logic [95:0] bank_read,
    input  logic [31:0] bank_pc_read
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {OWN_F, OWN_E, OWN_W} owner_t;

    state_t        state;
    owner_t        owner;
    owner_t        win;
    logic          any_req;
    logic [CW-1:0] f_cnt, e_cnt, w_cnt;
    logic          rd_q, err_q;

    // decoded bank access for the current arbitration winner
    logic          g_err, g_read, g_active, g_w, g_pc_inc, g_cpsr_w;
    logic [17:0]   g_addr;
    logic [31:0]   g_write, g_mask;
    logic [6:0]    m1, m2, m3;
    logic [4:0]    wr_idx;
    logic [31:0]   wr_data;

    // Returns {err, phys[5:0]} for an architectural index in the given mode.
    function automatic logic [6:0] map_idx(input logic [4:0] idx, input logic [4:0] mode);
        logic       err;
        logic [5:0] phys;
        logic [5:0] base;
        err  = 1'b0;
        phys = '0;
        base = 6'd13;
        case (mode)
            MODE_FIQ: base = 6'd21;
            MODE_SVC: base = 6'd23;
            MODE_ABT: base = 6'd25;
            MODE_IRQ: base = 6'd27;
            MODE_UND: base = 6'd29;
            MODE_USR, MODE_SYS: base = 6'd13;
            default: err = 1'b1;
        endcase
        if (idx <= 5'd7) begin
            phys = {1'b0, idx};
        end else if (idx <= 5'd12) begin
            phys = (mode == MODE_FIQ) ? ({1'b0, idx} + 6'd8) : {1'b0, idx};
        end else if (idx <= 5'd14) begin
            phys = base + {5'd0, (idx == 5'd14)};
        end else if (idx == 5'd15) begin
            phys = 6'd15;
        end else if (idx == 5'd16) begin
            phys = 6'd31;
        end else if (idx == 5'd17) begin
            case (mode)
                MODE_FIQ: phys = 6'd32;
                MODE_SVC: phys = 6'd33;
                MODE_ABT: phys = 6'd34;
                MODE_IRQ: phys = 6'd35;
                MODE_UND: phys = 6'd36;
                default:  err  = 1'b1;
            endcase
        end else begin
            err = 1'b1;
        end
        return {err, phys};
    endfunction

    // Arbitration: starved requesters first (W > E > F), then plain W > E > F.
    always_comb begin
        any_req = f_req | e_req | w_req;
        win     = OWN_F;
        if (w_req && (w_cnt == LIM))      win = OWN_W;
        else if (e_req && (e_cnt == LIM)) win = OWN_E;
        else if (f_req && (f_cnt == LIM)) win = OWN_F;
        else if (w_req)                   win = OWN_W;
        else if (e_req)                   win = OWN_E;
        else                              win = OWN_F;
    end

    // Decode the winner's operation into bank strobes; errors suppress all of them.
    always_comb begin
        g_err    = 1'b0;
        g_read   = 1'b0;
        g_active = 1'b0;
        g_w      = 1'b0;
        g_pc_inc = 1'b0;
        g_cpsr_w = 1'b0;
        g_addr   = '0;
        g_write  = '0;
        g_mask   = '0;
        wr_idx   = (win == OWN_W) ? w_addr : e_waddr;
        wr_data  = (win == OWN_W) ? w_data : e_wdata;
        m1       = map_idx(e_raddr[4:0],   cpsr_mode);
        m2       = map_idx(e_raddr[9:5],   cpsr_mode);
        m3       = map_idx(e_raddr[14:10], cpsr_mode);
        if (win == OWN_F) begin
            g_active = 1'b1;
            g_pc_inc = 1'b1;
        end else if (win == OWN_E && !e_we) begin
            g_err    = m1[6] | m2[6] | m3[6];
            g_read   = 1'b1;
            g_active = 1'b1;
            g_addr   = {m3[5:0], m2[5:0], m1[5:0]};
        end else begin
            m1      = map_idx(wr_idx, cpsr_mode);
            g_err   = m1[6];
            g_addr  = {12'd0, m1[5:0]};
            g_write = wr_data;
            // SPSR (17) lives in the GPR bank at 32-36, so it shares the GPR write strobe
            if (wr_idx == 5'd16) begin
                g_cpsr_w = 1'b1;
                g_mask   = CPSR_WMASK;
            end else begin
                g_w = 1'b1;
            end
        end
        if (g_err) begin
            g_read   = 1'b0;
            g_active = 1'b0;
            g_w      = 1'b0;
            g_cpsr_w = 1'b0;
            g_addr   = '0;
            g_write  = '0;
            g_mask   = '0;
        end
    end

    // Main FSM: grant in IDLE, strobes during ACCESS, ack/data pulse in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            owner          <= OWN_F;
            rd_q           <= 1'b0;
            err_q          <= 1'b0;
            f_cnt          <= '0;
            e_cnt          <= '0;
            w_cnt          <= '0;
            f_ack          <= 1'b0;
            f_pc           <= '0;
            e_ack          <= 1'b0;
            e_err          <= 1'b0;
            e_rdata        <= '0;
            w_ack          <= 1'b0;
            w_err          <= 1'b0;
            bank_active    <= 1'b0;
            bank_w         <= 1'b0;
            bank_pc_inc    <= 1'b0;
            bank_cpsr_w    <= 1'b0;
            bank_addr      <= '0;
            bank_write     <= '0;
            bank_cpsr_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state          <= ACCESS;
                        owner          <= win;
                        rd_q           <= g_read;
                        err_q          <= g_err;
                        bank_active    <= g_active;
                        bank_w         <= g_w;
                        bank_pc_inc    <= g_pc_inc;
                        bank_cpsr_w    <= g_cpsr_w;
                        bank_addr      <= g_addr;
                        bank_write     <= g_write;
                        bank_cpsr_mask <= g_mask;
                        if (win == OWN_F) f_cnt <= '0;
                        else if (f_req && f_cnt != LIM) f_cnt <= f_cnt + 1'b1;
                        if (win == OWN_E) e_cnt <= '0;
                        else if (e_req && e_cnt != LIM) e_cnt <= e_cnt + 1'b1;
                        if (win == OWN_W) w_cnt <= '0;
                        else if (w_req && w_cnt != LIM) w_cnt <= w_cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    state          <= RESP;
                    bank_active    <= 1'b0;
                    bank_w         <= 1'b0;
                    bank_pc_inc    <= 1'b0;
                    bank_cpsr_w    <= 1'b0;
                    bank_addr      <= '0;
                    bank_write     <= '0;
                    bank_cpsr_mask <= '0;
                    case (owner)
                        OWN_F: begin
                            f_ack <= 1'b1;
                            f_pc  <= bank_pc_read;
                        end
                        OWN_E: begin
                            e_ack   <= 1'b1;
                            e_err   <= err_q;
                            e_rdata <= rd_q ? bank_read : '0;
                        end
                        default: begin
                            w_ack <= 1'b1;
                            w_err <= err_q;
                        end
                    endcase
                end
                default: begin
                    state <= IDLE;
                    f_ack <= 1'b0;
                    e_ack <= 1'b0;
                    e_err <= 1'b0;
                    w_ack <= 1'b0;
                    w_err <= 1'b0;
                end
            endcase
        end
    end

endmodule
